// File: rtl/uart_expr_parser.sv
// ASCII expression parser: assembles "<A><op><B>" from UART bytes into binary operands
// for the ALU. Define PARSER_ECHO_EN to echo received bytes to uart_tx via a 1-entry buffer.
module uart_expr_parser #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              calc_ready,
  output logic              calc_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        op_sel,
`ifdef PARSER_ECHO_EN
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
`endif
  output logic              err
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_DIGITS);

  typedef enum logic [1:0] {StA, StB, StEmit, StErr} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_a_q, acc_a_d;
  logic [DATA_W-1:0]   acc_b_q, acc_b_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_sel_q, op_sel_d;
  logic                pend_err_q, pend_err_d;

  logic                is_digit, is_op, is_term, is_space, is_cr;
  logic [3:0]          digit;
  logic [1:0]          op_code;
  logic                rx_byte;

  function automatic logic [DATA_W-1:0] mac10(input logic [DATA_W-1:0] acc,
                                              input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {{(DATA_W-4){1'b0}}, d};
  endfunction

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    digit    = rx_data[3:0];
    is_space = (rx_data == 8'h20);
    is_cr    = (rx_data == 8'h0D);
    is_term  = is_cr || (rx_data == 8'h3D);
    is_op    = 1'b1;
    op_code  = 2'b00;
    case (rx_data)
      8'h2B:   op_code = 2'b00;
      8'h2D:   op_code = 2'b01;
      8'h2A:   op_code = 2'b10;
      8'h2F:   op_code = 2'b11;
      default: is_op = 1'b0;
    endcase
    // Spaces are transparent everywhere, so they never count as a received byte.
    rx_byte = rx_done && !is_space;
  end

  always_comb begin
    state_d    = state_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    cnt_d      = cnt_q;
    op_sel_d   = op_sel_q;
    pend_err_d = pend_err_q;
    unique case (state_q)
      StA: begin
        if (rx_byte) begin
          if (is_digit && cnt_q != CntMax) begin
            acc_a_d = mac10(acc_a_q, digit);
            cnt_d   = cnt_q + 1'b1;
          end else if (is_op && cnt_q != '0) begin
            op_sel_d = op_code;
            cnt_d    = '0;
            state_d  = StB;
          end else begin
            state_d = StErr;
          end
        end
      end
      StB: begin
        if (rx_byte) begin
          if (is_digit) begin
            acc_b_d = mac10(acc_b_q, digit);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CntMax) state_d = StEmit;
          end else if (is_term && cnt_q != '0) begin
            state_d = StEmit;
          end else begin
            state_d = StErr;
          end
        end
      end
      StEmit: begin
        // A byte arriving mid-handshake is dropped; the error takes effect after transfer.
        if (rx_byte) pend_err_d = 1'b1;
        if (calc_ready) begin
          acc_a_d    = '0;
          acc_b_d    = '0;
          cnt_d      = '0;
          pend_err_d = 1'b0;
          state_d    = (pend_err_q || rx_byte) ? StErr : StA;
        end
      end
      StErr: begin
        if (rx_done && is_cr) begin
          acc_a_d = '0;
          acc_b_d = '0;
          cnt_d   = '0;
          state_d = StA;
        end
      end
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StA;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      cnt_q      <= '0;
      op_sel_q   <= 2'b00;
      pend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      cnt_q      <= cnt_d;
      op_sel_q   <= op_sel_d;
      pend_err_q <= pend_err_d;
    end
  end

  assign calc_valid = (state_q == StEmit);
  assign err        = (state_q == StErr);
  assign op_a       = acc_a_q;
  assign op_b       = acc_b_q;
  assign op_sel     = op_sel_q;

`ifdef PARSER_ECHO_EN
  logic       echo_full_q, echo_full_d;
  logic [7:0] echo_data_q, echo_data_d;

  always_comb begin
    echo_full_d = echo_full_q;
    echo_data_d = echo_data_q;
    tx_start    = echo_full_q && !tx_busy;
    if (tx_start) echo_full_d = 1'b0;
    // Only an empty buffer takes a new byte; otherwise the echo is lost.
    if (rx_done && state_q != StErr && !echo_full_q) begin
      echo_full_d = 1'b1;
      echo_data_d = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_full_q <= 1'b0;
      echo_data_q <= 8'h00;
    end else begin
      echo_full_q <= echo_full_d;
      echo_data_q <= echo_data_d;
    end
  end

  assign tx_data = echo_data_q;
`endif

endmodule

// File: tb/tb_uart_expr_parser.sv
// Directed self-checking bench for uart_expr_parser (DATA_W=16, MAX_DIGITS=2).
// Echo checks are compiled in when PARSER_ECHO_EN is defined.
module tb_uart_expr_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        calc_ready;
  logic        calc_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  op_sel;
  logic        err;
`ifdef PARSER_ECHO_EN
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
`endif

  int checks = 0;
  int errors = 0;

  uart_expr_parser #(
    .DATA_W     (16),
    .MAX_DIGITS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .calc_ready (calc_ready),
    .calc_valid (calc_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sel     (op_sel),
`ifdef PARSER_ECHO_EN
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
`endif
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one byte strobe; returns on the negedge after the capture edge, then idles gap clks.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_done    = 1'b0;
    calc_ready = 1'b1;
`ifdef PARSER_ECHO_EN
    tx_busy    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, calc_valid}, 32'd0);
    check("rst_op_a", {16'd0, op_a}, 32'd0);
    check("rst_op_b", {16'd0, op_b}, 32'd0);
    check("rst_op_sel", {30'd0, op_sel}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: "87*93", B auto-terminates on its second digit
    send_byte(8'h38, 624);
    send_byte(8'h37, 624);
    send_byte(8'h2A, 624);
    send_byte(8'h39, 624);
    check("t1_pre_valid", {31'd0, calc_valid}, 32'd0);
    send_byte(8'h33, 0);
    check("t1_valid", {31'd0, calc_valid}, 32'd1);
    check("t1_op_a", {16'd0, op_a}, 32'd87);
    check("t1_op_b", {16'd0, op_b}, 32'd93);
    check("t1_op_sel", {30'd0, op_sel}, 32'd2);
    @(negedge clk);
    check("t1_pulse_end", {31'd0, calc_valid}, 32'd0);
    check("t1_err", {31'd0, err}, 32'd0);

    // 2: "5+7=" held off by calc_ready=0
    calc_ready = 1'b0;
    send_byte(8'h35, 2);
    send_byte(8'h2B, 2);
    send_byte(8'h37, 2);
    send_byte(8'h3D, 0);
    check("t2_valid", {31'd0, calc_valid}, 32'd1);
    check("t2_op_a", {16'd0, op_a}, 32'd5);
    check("t2_op_b", {16'd0, op_b}, 32'd7);
    check("t2_op_sel", {30'd0, op_sel}, 32'd0);
    repeat (10) @(negedge clk);
    check("t2_hold_valid", {31'd0, calc_valid}, 32'd1);
    check("t2_hold_a", {16'd0, op_a}, 32'd5);
    check("t2_hold_b", {16'd0, op_b}, 32'd7);
    calc_ready = 1'b1;
    @(negedge clk);
    check("t2_cleared", {31'd0, calc_valid}, 32'd0);
    check("t2_acc_clr", {16'd0, op_a}, 32'd0);

    // 3: error recovery only via CR
    send_byte(8'h31, 2);
    send_byte(8'h78, 0);
    check("t3_err", {31'd0, err}, 32'd1);
    send_byte(8'h34, 2);
    send_byte(8'h32, 2);
    check("t3_err_hold", {31'd0, err}, 32'd1);
    check("t3_no_valid", {31'd0, calc_valid}, 32'd0);
    send_byte(8'h0D, 0);
    check("t3_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h39, 2);
    send_byte(8'h2F, 2);
    send_byte(8'h33, 2);
    send_byte(8'h3D, 0);
    check("t3_valid", {31'd0, calc_valid}, 32'd1);
    check("t3_op_a", {16'd0, op_a}, 32'd9);
    check("t3_op_b", {16'd0, op_b}, 32'd3);
    check("t3_op_sel", {30'd0, op_sel}, 32'd3);
    @(negedge clk);

    // 4: too many digits in A; operator with no A digits
    send_byte(8'h31, 2);
    send_byte(8'h32, 2);
    check("t4_two_ok", {31'd0, err}, 32'd0);
    send_byte(8'h33, 0);
    check("t4_three_err", {31'd0, err}, 32'd1);
    send_byte(8'h0D, 2);
    send_byte(8'h2B, 0);
    check("t4_op_first", {31'd0, err}, 32'd1);
    send_byte(8'h0D, 2);
    check("t4_recover", {31'd0, err}, 32'd0);

    // Spaces are ignored: " 1 2 - 3 4" -> 12 - 34
    send_byte(8'h20, 1);
    send_byte(8'h31, 1);
    send_byte(8'h20, 1);
    send_byte(8'h32, 1);
    send_byte(8'h20, 1);
    send_byte(8'h2D, 1);
    send_byte(8'h20, 1);
    send_byte(8'h33, 1);
    send_byte(8'h20, 1);
    send_byte(8'h34, 0);
    check("sp_valid", {31'd0, calc_valid}, 32'd1);
    check("sp_op_a", {16'd0, op_a}, 32'd12);
    check("sp_op_b", {16'd0, op_b}, 32'd34);
    check("sp_op_sel", {30'd0, op_sel}, 32'd1);
    @(negedge clk);

    // Byte during a stalled emit: valid held, error only after transfer
    calc_ready = 1'b0;
    send_byte(8'h33, 1);
    send_byte(8'h2B, 1);
    send_byte(8'h34, 1);
    send_byte(8'h3D, 2);
    send_byte(8'h35, 1);
    check("em_valid_held", {31'd0, calc_valid}, 32'd1);
    check("em_op_a_held", {16'd0, op_a}, 32'd3);
    check("em_no_err_yet", {31'd0, err}, 32'd0);
    calc_ready = 1'b1;
    @(negedge clk);
    check("em_valid_drop", {31'd0, calc_valid}, 32'd0);
    check("em_err_after", {31'd0, err}, 32'd1);
    send_byte(8'h0D, 2);

    // 5: reset mid-expression
    send_byte(8'h38, 1);
    send_byte(8'h20, 1);
    send_byte(8'h37, 1);
    send_byte(8'h2A, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, calc_valid}, 32'd0);
    check("t5_rst_a", {16'd0, op_a}, 32'd0);
    check("t5_rst_sel", {30'd0, op_sel}, 32'd0);
    check("t5_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h32, 1);
    send_byte(8'h2D, 1);
    send_byte(8'h31, 1);
    send_byte(8'h3D, 0);
    check("t5_valid", {31'd0, calc_valid}, 32'd1);
    check("t5_op_a", {16'd0, op_a}, 32'd2);
    check("t5_op_b", {16'd0, op_b}, 32'd1);
    check("t5_op_sel", {30'd0, op_sel}, 32'd1);
    @(negedge clk);

`ifdef PARSER_ECHO_EN
    // 6: echo buffer holds one byte while tx is busy
    repeat (2) @(negedge clk);
    tx_busy = 1'b1;
    send_byte(8'h31, 1);
    send_byte(8'h32, 1);
    send_byte(8'h2B, 1);
    check("t6_busy_nostart", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b0;
    #1;
    check("t6_start", {31'd0, tx_start}, 32'd1);
    check("t6_data", {24'd0, tx_data}, 32'h31);
    @(negedge clk);
    check("t6_strobe_end", {31'd0, tx_start}, 32'd0);
    send_byte(8'h33, 1);
    send_byte(8'h3D, 0);
    check("t6_valid", {31'd0, calc_valid}, 32'd1);
    check("t6_op_a", {16'd0, op_a}, 32'd12);
    check("t6_op_b", {16'd0, op_b}, 32'd3);
    check("t6_op_sel", {30'd0, op_sel}, 32'd0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
